// File: rtl/mem_access_stage_pkg.sv
// Shared RV32I types for the memory-access stage: load/store funct3 encodings and stage FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_stage_state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational store lane alignment (mask + replicated data) and load byte/half extraction with extension.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_load,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half selection uses offset[1] only, so a stray bit 0 never shifts lanes.
  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    wmask = 4'b1111;
    wdata = store_data;
    if (!is_load) begin
      case (store_funct3_t'(funct3))
        sb: begin
          wmask = 4'b0001 << offset;
          wdata = {4{store_data[7:0]}};
        end
        sh: begin
          wmask = 4'b0011 << {offset[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_data = rdata;
    case (load_funct3_t'(funct3))
      lb:      load_data = {{24{byte_sel[7]}}, byte_sel};
      lbu:     load_data = {24'b0, byte_sel};
      lh:      load_data = {{16{half_sel[15]}}, half_sel};
      lhu:     load_data = {16'b0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: issues/holds the D-memory request until dmem_resp, registers load data into MDR, drives stall/advance.
// Optional MEM_ACCESS_MISALIGN_CHECK_EN blocks misaligned half/word accesses and flags them on misaligned_o.
module mem_access_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        hold_i,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mdr_o,
  output logic        stall_o,
  output logic        advance_o
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  ,
  output logic        misaligned_o
`endif
);

  mem_stage_state_t state, state_next;
  logic        access;
  logic        is_load;
  logic        is_store;
  logic        misal;
  logic        go;
  logic        req;
  logic [31:0] load_data;
  logic [31:0] mdr_q;

  assign access   = valid_i && (mem_read_i || mem_write_i);
  // Both flags set resolves to a load.
  assign is_load  = mem_read_i;
  assign is_store = mem_write_i && !mem_read_i;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign misal = access &&
                 (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                  ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
  assign misaligned_o = (state == IDLE) && misal;
`else
  assign misal = 1'b0;
`endif

  assign go = access && !misal;

  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          req        = 1'b1;
          stall_o    = 1'b1;
          state_next = dmem_resp ? DONE : WAIT;
        end
      end
      WAIT: begin
        req     = 1'b1;
        stall_o = 1'b1;
        if (dmem_resp) state_next = DONE;
      end
      DONE: begin
        if (!hold_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mdr_q <= 32'b0;
    end else begin
      state <= state_next;
      if (req && dmem_resp && is_load) mdr_q <= load_data;
    end
  end

  mem_align u_align (
    .funct3     (funct3_i),
    .offset     (addr_i[1:0]),
    .is_load    (is_load),
    .store_data (store_data_i),
    .rdata      (dmem_rdata),
    .wmask      (dmem_wmask),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  assign dmem_read    = req && is_load;
  assign dmem_write   = req && is_store;
  assign dmem_address = {addr_i[31:2], 2'b00};
  assign mdr_o        = mdr_q;
  assign advance_o    = !stall_o && !hold_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level expectations checked every cycle plus literal pins.
module tb_mem_access_stage;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read_i, mem_write_i, hold_i, dmem_resp;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i, dmem_rdata;
  logic        dmem_read, dmem_write, stall_o, advance_o;
  logic [31:0] dmem_address, dmem_wdata, mdr_o;
  logic [3:0]  dmem_wmask;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic        misaligned_o;
`endif

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .hold_i       (hold_i),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .mdr_o        (mdr_o),
    .stall_o      (stall_o),
    .advance_o    (advance_o)
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    ,
    .misaligned_o (misaligned_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic        exp_stall, exp_rd, exp_wr, exp_adv, exp_mis;
  logic [3:0]  exp_mask;
  logic [31:0] exp_addr, exp_wdata, exp_mdr;
  bit          chk_en = 1'b0;
  int          stall_cnt;
  logic [3:0]  last_wmask;
  logic [31:0] last_wdata, last_raddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected load result: shift the word so the addressed lane lands at bit 0, then extend.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * a[1:0]);
    h = w >> (16 * a[1]);
    case (f3)
      F_B:     return {{24{b[7]}}, b[7:0]};
      F_BU:    return {24'b0, b[7:0]};
      F_H:     return {{16{h[15]}}, h[15:0]};
      F_HU:    return {16'b0, h[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      F_B:     return 4'(1 << a[1:0]);
      F_H:     return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F_B:     return {4{d[7:0]}};
      F_H:     return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall_o), 32'(exp_stall));
      chk("advance", 32'(advance_o), 32'(exp_adv));
      chk("dmem_read", 32'(dmem_read), 32'(exp_rd));
      chk("dmem_write", 32'(dmem_write), 32'(exp_wr));
      chk("mdr", mdr_o, exp_mdr);
      if (exp_rd || exp_wr) begin
        chk("address", dmem_address, exp_addr);
        chk("wmask", 32'(dmem_wmask), 32'(exp_mask));
      end
      if (exp_wr) chk("wdata", dmem_wdata, exp_wdata);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      chk("misaligned", 32'(misaligned_o), 32'(exp_mis));
`endif
      if (stall_o) stall_cnt++;
      if (dmem_write) begin
        last_wmask = dmem_wmask;
        last_wdata = dmem_wdata;
      end
      if (dmem_read) last_raddr = dmem_address;
    end
  end

  task automatic set_idle();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    hold_i = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_adv = 1'b1; exp_mis = 1'b0;
  endtask

  // lat: cycles of waiting before the response (0 = response in the request cycle).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                            input int lat, input int hold_n, input bit hold_wait);
    logic ld, st, mis;
    ld  = rd;
    st  = wr && !rd;
    mis = (rd || wr) && m_mis(f3, a);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = a; store_data_i = d; hold_i = 1'b0; dmem_resp = 1'b0;
    stall_cnt = 0;
    if (mis || !(rd || wr)) begin
      exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_adv = 1'b1; exp_mis = mis;
      @(posedge clk); #1;
    end else begin
      exp_addr  = {a[31:2], 2'b00};
      exp_mask  = st ? m_mask(f3, a) : 4'hF;
      exp_wdata = m_wdata(f3, d);
      for (int c = 0; c <= lat; c++) begin
        exp_stall = 1'b1; exp_rd = ld; exp_wr = st; exp_adv = 1'b0;
        hold_i     = hold_wait && (c > 0);
        dmem_resp  = (c == lat);
        dmem_rdata = (c == lat) ? rdat : 32'h5A5A_5A5A;
        @(posedge clk); #1;
      end
      if (ld) exp_mdr = m_load(f3, a, rdat);
      for (int h = 0; h <= hold_n; h++) begin
        exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        hold_i     = (h < hold_n);
        exp_adv    = !hold_i;
        dmem_resp  = hold_i;
        dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
      end
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    funct3_i = F_W; addr_i = 32'h0; store_data_i = 32'h0;
    set_idle();
    exp_mdr = 32'h0; exp_addr = 32'h0; exp_mask = 4'hF; exp_wdata = 32'h0;
    stall_cnt = 0; last_wmask = 4'h0; last_wdata = 32'h0; last_raddr = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_mdr", mdr_o, 32'h0);
    chk("reset_stall", 32'(stall_o), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_access(1, 0, F_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0, 0);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lw_mdr", mdr_o, 32'hDEAD_BEEF);
    chk("lw_addr", last_raddr, 32'h100);

    run_access(1, 0, F_B, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 0);
    chk("lb_mdr", mdr_o, 32'hFFFF_FF80);
    run_access(1, 0, F_BU, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0);
    chk("lbu_mdr", mdr_o, 32'h0000_0080);
    chk("zero_wait_stall", 32'(stall_cnt), 32'd1);

    run_access(0, 1, F_H, 32'h202, 32'h0000_ABCD, 32'h0, 3, 0, 0);
    chk("sh_wmask", 32'(last_wmask), 32'h0000_000C);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_mdr_kept", mdr_o, 32'h0000_0080);

    run_access(1, 0, F_W, 32'h110, 32'h0, 32'hCAFE_F00D, 0, 2, 0);
    chk("hold_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("hold_mdr", mdr_o, 32'hCAFE_F00D);

    run_access(0, 1, F_B, 32'h301, 32'h1234_5678, 32'h0, 1, 0, 0);
    chk("sb_wmask", 32'(last_wmask), 32'h0000_0002);
    chk("sb_wdata", last_wdata, 32'h7878_7878);
    run_access(0, 1, F_W, 32'h400, 32'h0BAD_CAFE, 32'h0, 0, 0, 0);
    run_access(1, 0, F_H, 32'h102, 32'h0, 32'h8001_7FFF, 1, 0, 0);
    chk("lh_mdr", mdr_o, 32'hFFFF_8001);
    run_access(1, 0, F_HU, 32'h100, 32'h0, 32'h8001_7FFF, 2, 0, 0);
    chk("lhu_mdr", mdr_o, 32'h0000_7FFF);
    run_access(1, 1, F_W, 32'h104, 32'hFFFF_FFFF, 32'h0102_0304, 1, 1, 0);
    run_access(1, 0, F_W, 32'h108, 32'h0, 32'h7777_0001, 3, 0, 1);
    chk("hold_wait_stall_cycles", 32'(stall_cnt), 32'd4);
    run_access(0, 0, F_W, 32'h10C, 32'h0, 32'h0, 0, 0, 0);

    // Bubble carrying a stale load flag must not request.
    mem_read_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    set_idle();

    run_access(1, 0, F_W, 32'h101, 32'h0, 32'h1111_2222, 1, 0, 0);
    run_access(0, 1, F_H, 32'h203, 32'h0000_5A5A, 32'h0, 0, 0, 0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    chk("mis_mdr_kept", mdr_o, 32'h7777_0001);
    valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = F_W; addr_i = 32'h101;
    exp_mis = 1'b1;
    #2;
    chk("mis_flag", 32'(misaligned_o), 32'h1);
    chk("mis_no_read", 32'(dmem_read), 32'h0);
    chk("mis_no_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    set_idle();
`else
    chk("unaligned_lw_mdr", mdr_o, 32'h1111_2222);
    chk("unaligned_sh_wmask", 32'(last_wmask), 32'h0000_000C);
`endif

    // Reset while waiting: the late response must not reach MDR.
    valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = F_W; addr_i = 32'h500;
    exp_addr = 32'h500; exp_mask = 4'hF;
    exp_stall = 1'b1; exp_rd = 1'b1; exp_adv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    exp_mdr = 32'h0;
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("rst_wait_mdr", mdr_o, 32'h0);
    chk("rst_wait_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
